// File: rtl/video_timing_if.sv
// Pixel-source and video-output signal bundle for video_timing_gen.
// The master side is the timing generator; the slave side is the source/sink.
interface video_timing_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  i_en;
  logic                  o_data_req;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_hs;
  logic                  o_vs;
  logic                  o_de;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_sof;
  logic [12:0]           o_x;
  logic [12:0]           o_y;
  logic                  o_busy;

  modport master (
    input  i_en, i_data,
    output o_data_req, o_hs, o_vs, o_de, o_data, o_sof, o_x, o_y, o_busy
  );

  modport slave (
    output i_en, i_data,
    input  o_data_req, o_hs, o_vs, o_de, o_data, o_sof, o_x, o_y, o_busy
  );
endinterface

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: counts h/v, requests one pixel per active
// cycle from a 1-cycle-latency source and emits aligned hs/vs/de/data/x/y.
module video_timing_gen #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter int HS_POL     = 1,
  parameter int VS_POL     = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  video_timing_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_S = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_E = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] H_LAST   = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_S = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_E = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [12:0] V_LAST   = 13'(V_TOTAL - 1);
  localparam logic        HS_ON    = (HS_POL != 0);
  localparam logic        VS_ON    = (VS_POL != 0);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t state, state_nxt;

  function automatic logic sync_level(input logic act, input logic on_lvl);
    return act ? on_lvl : ~on_lvl;
  endfunction

  // ---- stage 0: FSM and raster counters ----
  logic [12:0] h_cnt_p0, v_cnt_p0;
  logic        running_p0, frame_end_p0;

  assign running_p0   = (state != IDLE);
  assign frame_end_p0 = (h_cnt_p0 == H_LAST) && (v_cnt_p0 == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stopping only takes effect at frame end, so a frame is never cut short.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.i_en) state_nxt = RUN;
      RUN:  if (!bus.i_en) state_nxt = frame_end_p0 ? IDLE : STOP;
      STOP: begin
        if (bus.i_en)        state_nxt = RUN;
        else if (frame_end_p0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (!running_p0) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (h_cnt_p0 == H_LAST) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? 13'd0 : v_cnt_p0 + 13'd1;
    end else begin
      h_cnt_p0 <= h_cnt_p0 + 13'd1;
    end
  end

  logic h_act_p0, v_act_p0, de_raw_p0, hs_raw_p0, vs_raw_p0, sof_raw_p0;

  assign h_act_p0   = (h_cnt_p0 < H_ACT);
  assign v_act_p0   = (v_cnt_p0 < V_ACT);
  assign de_raw_p0  = running_p0 && h_act_p0 && v_act_p0;
  assign hs_raw_p0  = running_p0 && (h_cnt_p0 >= H_SYNC_S) && (h_cnt_p0 < H_SYNC_E);
  assign vs_raw_p0  = running_p0 && (v_cnt_p0 >= V_SYNC_S) && (v_cnt_p0 < V_SYNC_E);
  assign sof_raw_p0 = running_p0 && (h_cnt_p0 == 13'd0) && (v_cnt_p0 == 13'd0);

  // ---- stage 1: pixel request and timing flags ----
  logic        vld_p1, hs_p1, vs_p1, sof_p1;
  logic [12:0] x_p1, y_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      sof_p1 <= 1'b0;
      x_p1   <= '0;
      y_p1   <= '0;
    end else begin
      vld_p1 <= de_raw_p0;
      hs_p1  <= hs_raw_p0;
      vs_p1  <= vs_raw_p0;
      sof_p1 <= sof_raw_p0;
      x_p1   <= de_raw_p0 ? h_cnt_p0 : 13'd0;
      y_p1   <= (running_p0 && v_act_p0) ? v_cnt_p0 : 13'd0;
    end
  end

  assign bus.o_data_req = vld_p1;
  assign bus.o_busy     = running_p0;

  // ---- stage 2: wait for the source's one-cycle data latency ----
  logic        vld_p2, hs_p2, vs_p2, sof_p2;
  logic [12:0] x_p2, y_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
      sof_p2 <= 1'b0;
      x_p2   <= '0;
      y_p2   <= '0;
    end else begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      sof_p2 <= sof_p1;
      x_p2   <= x_p1;
      y_p2   <= y_p1;
    end
  end

  // ---- output stage: everything registered together with the pixel ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_de   <= 1'b0;
      bus.o_data <= '0;
      bus.o_hs   <= ~HS_ON;
      bus.o_vs   <= ~VS_ON;
      bus.o_sof  <= 1'b0;
      bus.o_x    <= '0;
      bus.o_y    <= '0;
    end else begin
      bus.o_de   <= vld_p2;
      bus.o_data <= vld_p2 ? bus.i_data : '0;
      bus.o_hs   <= sync_level(hs_p2, HS_ON);
      bus.o_vs   <= sync_level(vs_p2, VS_ON);
      bus.o_sof  <= sof_p2;
      bus.o_x    <= x_p2;
      bus.o_y    <= y_p2;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a 14x7 raster, plus a short
// horizontal-timing check of the default 1080p configuration.
module tb_video_timing_gen;

  localparam int H_A = 8, H_F = 2, H_S = 2, H_B = 2;
  localparam int V_A = 4, V_F = 1, V_S = 1, V_B = 1;
  localparam int H_TOT = H_A + H_F + H_S + H_B;
  localparam int V_TOT = V_A + V_F + V_S + V_B;
  localparam int FRAME = H_TOT * V_TOT;
  localparam bit HS_P = 1'b1;
  localparam bit VS_P = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_timing_if #(.DATA_WIDTH(24)) vif ();
  video_timing_if #(.DATA_WIDTH(24)) vif2 ();

  video_timing_gen #(
    .DATA_WIDTH(24), .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
    .HS_POL(1), .VS_POL(0)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(vif));

  video_timing_gen dut_1080p (.clk(clk), .rst_n(rst_n), .bus(vif2));

  typedef struct { bit run; int idx; } pos_t;
  typedef struct {
    bit hs, vs, de, sof, busy, req;
    bit [23:0] data;
    int x, y;
  } exp_t;

  int n_cmp = 0;
  int n_fail = 0;
  exp_t q[$];
  pos_t cur;
  pos_t hist[3];
  exp_t last_exp;
  int src_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [23:0] pix(input int x, input int y);
    return {12'(x), 12'(y)};
  endfunction

  // Reference view: a running frame is a linear index 0..FRAME-1 into the raster.
  function automatic bit is_active(input pos_t p);
    return p.run && (p.idx % H_TOT) < H_A && (p.idx / H_TOT) < V_A;
  endfunction

  function automatic exp_t expect_from(input pos_t p3, input pos_t p1, input bit busy);
    exp_t e;
    int h, v;
    h = p3.idx % H_TOT;
    v = p3.idx / H_TOT;
    e.de   = is_active(p3);
    e.x    = e.de ? h : 0;
    e.y    = (p3.run && v < V_A) ? v : 0;
    e.sof  = p3.run && p3.idx == 0;
    e.hs   = (p3.run && h >= H_A + H_F && h < H_A + H_F + H_S) ? HS_P : !HS_P;
    e.vs   = (p3.run && v >= V_A + V_F && v < V_A + V_F + V_S) ? VS_P : !VS_P;
    e.data = e.de ? pix(h, v) : 24'd0;
    e.req  = is_active(p1);
    e.busy = busy;
    return e;
  endfunction

  function automatic pos_t next_pos(input pos_t p, input bit en);
    pos_t n;
    n = p;
    if (!p.run) begin
      n.run = en;
      n.idx = 0;
    end else if (p.idx == FRAME - 1) begin
      n.run = en;
      n.idx = 0;
    end else begin
      n.idx = p.idx + 1;
    end
    return n;
  endfunction

  function automatic pos_t idle_pos();
    pos_t p;
    p.run = 1'b0;
    p.idx = 0;
    return p;
  endfunction

  task automatic model_reset();
    cur = idle_pos();
    for (int i = 0; i < 3; i++) hist[i] = idle_pos();
  endtask

  // Called right after each rising edge: advances the model and queues that cycle's outputs.
  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = cur;
      cur = next_pos(cur, vif.i_en);
    end
    last_exp = expect_from(hist[2], hist[0], cur.run);
    q.push_back(last_exp);
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_update();
      #1 vif.i_en = en;
    end
  endtask

  // Pixel source: answers each request one cycle later with {x,y} of the nth requested pixel.
  initial begin : source
    bit pend;
    pend = 1'b0;
    vif.i_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        src_n = 0;
        pend = 1'b0;
      end else begin
        pend = vif.o_data_req;
      end
      @(posedge clk);
      #1;
      if (pend) begin
        vif.i_data = pix(src_n % H_A, (src_n / H_A) % V_A);
        src_n++;
      end else begin
        vif.i_data = 24'($urandom);
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("de",   32'(vif.o_de),       32'(e.de));
      chk("data", 32'(vif.o_data),     32'(e.data));
      chk("x",    32'(vif.o_x),        32'(e.x));
      chk("y",    32'(vif.o_y),        32'(e.y));
      chk("hs",   32'(vif.o_hs),       32'(e.hs));
      chk("vs",   32'(vif.o_vs),       32'(e.vs));
      chk("sof",  32'(vif.o_sof),      32'(e.sof));
      chk("req",  32'(vif.o_data_req), 32'(e.req));
      chk("busy", 32'(vif.o_busy),     32'(e.busy));
    end
  end

  initial begin : main
    int de_cnt, xmax, hs_off, period, y0;
    bit found, fell;
    vif.i_en = 1'b0;
    vif2.i_en = 1'b0;
    vif2.i_data = '0;
    model_reset();

    run(4, 1'b0);
    rst_n = 1'b1;

    // idle with i_en low
    run(50, 1'b0);

    // continuous frames
    run(3 * FRAME + 10, 1'b1);
    run(FRAME, 1'b0);

    // drop i_en mid-frame, reassert before the frame ends, then stop for good
    run(1, 1'b1);
    run(40, 1'b1);
    run(20, 1'b0);
    run(10, 1'b1);
    run(40, 1'b1);
    run(2 * FRAME, 1'b0);

    // randomized run/stop pattern
    for (int s = 0; s < 30; s++)
      run($urandom_range(1, 150), 1'($urandom_range(0, 1)));
    run(2 * FRAME, 1'b0);

    // reset in the middle of an active line
    run(1, 1'b1);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (last_exp.de && last_exp.x == 3) break;
      run(1, 1'b1);
    end
    rst_n = 1'b0;
    q.delete();
    model_reset();
    last_exp = expect_from(hist[2], hist[0], 1'b0);
    q.push_back(last_exp);
    run(3, 1'b1);
    rst_n = 1'b1;
    run(FRAME + 20, 1'b1);
    run(2 * FRAME, 1'b0);
    @(negedge clk);

    // default 1080p instance: line 0 horizontal timing
    @(posedge clk);
    #1 vif2.i_en = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 5000 && !found; t++) begin
      @(negedge clk);
      if (vif2.o_de) found = 1'b1;
    end
    chk("dflt_de_rise", 32'(found), 32'd1);
    y0 = int'(vif2.o_y);
    de_cnt = 0; xmax = 0; hs_off = -1; period = -1; fell = 1'b0;
    if (found) begin
      for (int k = 0; k < 5000; k++) begin
        if (vif2.o_de && !fell) begin
          de_cnt++;
          if (int'(vif2.o_x) > xmax) xmax = int'(vif2.o_x);
        end
        if (!vif2.o_de) fell = 1'b1;
        if (vif2.o_hs && hs_off < 0) hs_off = k;
        if (fell && vif2.o_de) begin
          period = k;
          break;
        end
        @(negedge clk);
      end
    end
    chk("dflt_de_count", 32'(de_cnt), 32'd1920);
    chk("dflt_x_max",    32'(xmax),   32'd1919);
    chk("dflt_y_line0",  32'(y0),     32'd0);
    chk("dflt_hs_offset", 32'(hs_off), 32'd2008);
    chk("dflt_h_total",  32'(period), 32'd2200);
    vif2.i_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
